// File: rtl/bw_pkg.sv
// Shared definitions for the bandwidth-edge interpolation slice.
// Purpose : default widths, the -30 dB Q.8 threshold constant, the
//           interpolator FSM state type and the PREP classification type.
// Ports   : none (package).
package bw_pkg;

    localparam int ACCUM_WIDTH    = 18;
    localparam int FREQ_BIN_WIDTH = 16;
    localparam int FRAC_BITS      = 8;

    // -30.0 dB in the signed Q.8 accumulator domain.
    localparam logic [ACCUM_WIDTH-1:0] TH_M30_DB = 18'h3E200;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        DIV,
        MUL,
        DONE
    } state_e;

    // How the interpolation fraction q is obtained for one request.
    typedef enum logic [1:0] {
        CLS_DIVIDE,
        CLS_ZERO,
        CLS_NEG,
        CLS_CLAMP
    } class_e;

endpackage

// File: rtl/bw_edge_interp_if.sv
// Request/result bundle of the edge interpolator.
// Purpose : groups the start strobe, bracketing pair, threshold and the
//           result/status signals of bw_edge_interp.
// Ports   : master drives start_i, f1_i, f2_i, L1_i, L2_i, threshold_i and
//           observes f_edge_o, valid_o, busy_o, err_o; slave is the reverse.
interface bw_edge_interp_if #(
    parameter int ACCUM_WIDTH    = bw_pkg::ACCUM_WIDTH,
    parameter int FREQ_BIN_WIDTH = bw_pkg::FREQ_BIN_WIDTH,
    parameter int FRAC_BITS      = bw_pkg::FRAC_BITS
);

    logic                                start_i;
    logic [FREQ_BIN_WIDTH-1:0]           f1_i;
    logic [FREQ_BIN_WIDTH-1:0]           f2_i;
    logic [ACCUM_WIDTH-1:0]              L1_i;
    logic [ACCUM_WIDTH-1:0]              L2_i;
    logic [ACCUM_WIDTH-1:0]              threshold_i;
    logic [FREQ_BIN_WIDTH+FRAC_BITS-1:0] f_edge_o;
    logic                                valid_o;
    logic                                busy_o;
    logic                                err_o;

    modport master (
        output start_i, f1_i, f2_i, L1_i, L2_i, threshold_i,
        input  f_edge_o, valid_o, busy_o, err_o
    );

    modport slave (
        input  start_i, f1_i, f2_i, L1_i, L2_i, threshold_i,
        output f_edge_o, valid_o, busy_o, err_o
    );

endinterface

// File: rtl/bw_restoring_div.sv
// Serial unsigned restoring divider producing a pure fraction.
// Purpose : quotient_o = floor(dividend * 2^FRAC_BITS / divisor), one bit
//           per cycle, truncated. Meaningful only when dividend < divisor.
// Ports   : clk_i, rst_ni (async active-low), start_i loads the operands,
//           dividend_i/divisor_i operands, quotient_o result, done_o high
//           during the final iteration cycle (quotient valid the cycle after).
module bw_restoring_div #(
    parameter int OP_WIDTH  = 19,
    parameter int FRAC_BITS = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [OP_WIDTH-1:0]  dividend_i,
    input  logic [OP_WIDTH-1:0]  divisor_i,
    output logic [FRAC_BITS-1:0] quotient_o,
    output logic                 done_o
);

    localparam int CNT_W = $clog2(FRAC_BITS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAC_BITS - 1);

    logic [OP_WIDTH-1:0]  rem_q, rem_d;
    logic [OP_WIDTH-1:0]  dsr_q, dsr_d;
    logic [FRAC_BITS-1:0] quo_q, quo_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 run_q, run_d;

    logic [OP_WIDTH:0]    rem_sh;
    logic                 fits;

    // The shifted remainder needs one extra bit; with rem < d it stays below
    // 2d, so after the conditional subtract it fits OP_WIDTH bits again.
    always_comb begin
        rem_sh = {rem_q, 1'b0};
        fits   = (rem_sh >= {1'b0, dsr_q});
        rem_d  = rem_q;
        dsr_d  = dsr_q;
        quo_d  = quo_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        if (start_i) begin
            rem_d = dividend_i;
            dsr_d = divisor_i;
            quo_d = '0;
            cnt_d = '0;
            run_d = 1'b1;
        end else if (run_q) begin
            rem_d = fits ? OP_WIDTH'(rem_sh - {1'b0, dsr_q}) : rem_sh[OP_WIDTH-1:0];
            quo_d = FRAC_BITS'({quo_q, fits});
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rem_q <= '0;
            dsr_q <= '0;
            quo_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            rem_q <= rem_d;
            dsr_q <= dsr_d;
            quo_q <= quo_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    assign quotient_o = quo_q;
    assign done_o     = run_q && (cnt_q == LAST);

endmodule

// File: rtl/bw_edge_interp.sv
// Sub-bin interpolation of the threshold crossing between two bins.
// Purpose : f_edge = f1 + (f2 - f1) * (TH - L1) / (L2 - L1) with FRAC_BITS
//           fractional bits; fixed latency regardless of the operand case.
// Ports   : clk_i, rst_ni (async active-low), bus (slave modport):
//           start_i request, f1_i/f2_i bracketing bins, L1_i/L2_i levels,
//           threshold_i level, f_edge_o result, valid_o strobe, busy_o
//           in-flight flag, err_o degenerate pair (L1 == L2).
module bw_edge_interp
    import bw_pkg::*;
#(
    parameter int ACCUM_WIDTH    = bw_pkg::ACCUM_WIDTH,
    parameter int FREQ_BIN_WIDTH = bw_pkg::FREQ_BIN_WIDTH,
    parameter int FRAC_BITS      = bw_pkg::FRAC_BITS
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    bw_edge_interp_if.slave  bus
);

    localparam int NW = ACCUM_WIDTH + 1;
    localparam int OW = FREQ_BIN_WIDTH + FRAC_BITS;

    state_e                    state_q, state_d;
    logic [FREQ_BIN_WIDTH-1:0] f1_q, f1_d, f2_q, f2_d, df_q, df_d;
    logic [ACCUM_WIDTH-1:0]    l1_q, l1_d, l2_q, l2_d, th_q, th_d;
    class_e                    cls_q, cls_d;
    logic [OW-1:0]             res_q, res_d, f_edge_q, f_edge_d;
    logic                      res_err_q, res_err_d;
    logic                      valid_q, valid_d, busy_q, busy_d, err_q, err_d;

    logic signed [NW-1:0]      num_c, den_c;
    logic [NW-1:0]             n_c, d_c;
    class_e                    cls_c;
    logic [FRAC_BITS-1:0]      div_quo;
    logic                      div_done;
    logic [FRAC_BITS:0]        q_c;
    logic [OW-1:0]             mul_c;

    // Differences are taken one bit wider than the levels so they never wrap.
    always_comb begin
        num_c = $signed({th_q[ACCUM_WIDTH-1], th_q}) - $signed({l1_q[ACCUM_WIDTH-1], l1_q});
        den_c = $signed({l2_q[ACCUM_WIDTH-1], l2_q}) - $signed({l1_q[ACCUM_WIDTH-1], l1_q});
        n_c   = num_c[NW-1] ? $unsigned(-num_c) : $unsigned(num_c);
        d_c   = den_c[NW-1] ? $unsigned(-den_c) : $unsigned(den_c);
        if (den_c == '0) begin
            cls_c = CLS_ZERO;
        end else if ((num_c != '0) && (num_c[NW-1] != den_c[NW-1])) begin
            cls_c = CLS_NEG;
        end else if (n_c >= d_c) begin
            cls_c = CLS_CLAMP;
        end else begin
            cls_c = CLS_DIVIDE;
        end
    end

    // The divider runs on every request so latency does not depend on the
    // class; its quotient is simply ignored for the non-divide classes.
    bw_restoring_div #(
        .OP_WIDTH  (NW),
        .FRAC_BITS (FRAC_BITS)
    ) u_div (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .start_i    (state_q == PREP),
        .dividend_i (n_c),
        .divisor_i  (d_c),
        .quotient_o (div_quo),
        .done_o     (div_done)
    );

    // q is at most 2^FRAC_BITS, so f1<<FRAC_BITS + df*q never exceeds f2<<FRAC_BITS.
    always_comb begin
        case (cls_q)
            CLS_DIVIDE: q_c = {1'b0, div_quo};
            CLS_CLAMP:  q_c = {1'b1, {FRAC_BITS{1'b0}}};
            default:    q_c = '0;
        endcase
        mul_c = {f1_q, {FRAC_BITS{1'b0}}} + OW'(df_q) * OW'(q_c);
    end

    always_comb begin
        state_d   = state_q;
        f1_d      = f1_q;
        f2_d      = f2_q;
        l1_d      = l1_q;
        l2_d      = l2_q;
        th_d      = th_q;
        df_d      = df_q;
        cls_d     = cls_q;
        res_d     = res_q;
        res_err_d = res_err_q;
        f_edge_d  = f_edge_q;
        err_d     = err_q;
        busy_d    = busy_q;
        valid_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    f1_d    = bus.f1_i;
                    f2_d    = bus.f2_i;
                    l1_d    = bus.L1_i;
                    l2_d    = bus.L2_i;
                    th_d    = bus.threshold_i;
                    busy_d  = 1'b1;
                    state_d = PREP;
                end
            end
            PREP: begin
                df_d    = f2_q - f1_q;
                cls_d   = cls_c;
                state_d = DIV;
            end
            DIV: begin
                if (div_done) begin
                    state_d = MUL;
                end
            end
            MUL: begin
                res_d     = mul_c;
                res_err_d = (cls_q == CLS_ZERO);
                state_d   = DONE;
            end
            DONE: begin
                f_edge_d = res_q;
                err_d    = res_err_q;
                valid_d  = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            f1_q      <= '0;
            f2_q      <= '0;
            l1_q      <= '0;
            l2_q      <= '0;
            th_q      <= '0;
            df_q      <= '0;
            cls_q     <= CLS_DIVIDE;
            res_q     <= '0;
            res_err_q <= 1'b0;
            f_edge_q  <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            f1_q      <= f1_d;
            f2_q      <= f2_d;
            l1_q      <= l1_d;
            l2_q      <= l2_d;
            th_q      <= th_d;
            df_q      <= df_d;
            cls_q     <= cls_d;
            res_q     <= res_d;
            res_err_q <= res_err_d;
            f_edge_q  <= f_edge_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
        end
    end

    assign bus.f_edge_o = f_edge_q;
    assign bus.valid_o  = valid_q;
    assign bus.busy_o   = busy_q;
    assign bus.err_o    = err_q;

endmodule

// File: tb/tb_bw_edge_interp.sv
// Self-checking bench for bw_edge_interp.
// Purpose : directed vectors with literal expectations, plus an arithmetic
//           reference model compared against the outputs every cycle.
// Ports   : none (top-level bench).
module tb_bw_edge_interp;
    import bw_pkg::*;

    localparam int LAT = FRAC_BITS + 3;

    typedef struct {
        string       name;
        logic [15:0] f1;
        logic [15:0] f2;
        logic [17:0] l1;
        logic [17:0] l2;
        logic [17:0] th;
        logic [23:0] fe;
        logic        err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    bw_edge_interp_if bus();

    bw_edge_interp dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic compareValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: straight arithmetic on dB levels as plain integers.
    function automatic void refModel(input logic [15:0] f1, input logic [15:0] f2,
                                     input logic [17:0] l1, input logic [17:0] l2,
                                     input logic [17:0] th,
                                     output logic [23:0] fe, output logic err);
        logic signed [17:0] s;
        int    a1, a2, at, num, den, n, d;
        longint q;
        s = l1; a1 = s;
        s = l2; a2 = s;
        s = th; at = s;
        num = at - a1;
        den = a2 - a1;
        err = 1'b0;
        if (den == 0) begin
            err = 1'b1;
            q   = 0;
        end else if (num == 0 || ((num < 0) != (den < 0))) begin
            q = 0;
        end else begin
            n = (num < 0) ? -num : num;
            d = (den < 0) ? -den : den;
            q = (n >= d) ? (longint'(1) << FRAC_BITS) : ((longint'(n) << FRAC_BITS) / d);
        end
        fe = 24'((longint'(f1) << FRAC_BITS) + (longint'(f2) - longint'(f1)) * q);
    endfunction

    // Model state: expected outputs as seen after each rising edge.
    logic        m_active, m_valid, m_err, m_prev, p_err;
    logic [23:0] m_fe, p_fe;
    int          m_k;

    // A request is accepted only if the model was idle before this edge; the
    // result appears LAT edges later and is held until the next result.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_valid  = 1'b0;
            m_fe     = '0;
            m_err    = 1'b0;
            m_k      = 0;
        end else begin
            m_prev  = m_active;
            m_valid = 1'b0;
            if (m_active) begin
                m_k++;
                if (m_k == LAT) begin
                    m_active = 1'b0;
                    m_valid  = 1'b1;
                    m_fe     = p_fe;
                    m_err    = p_err;
                end
            end
            if (!m_prev && bus.start_i) begin
                refModel(bus.f1_i, bus.f2_i, bus.L1_i, bus.L2_i, bus.threshold_i, p_fe, p_err);
                m_active = 1'b1;
                m_k      = 0;
            end
        end
    end

    always @(negedge clk) begin
        compareValue("model_valid", 32'(bus.valid_o), 32'(m_valid));
        compareValue("model_busy", 32'(bus.busy_o), 32'(m_active));
        compareValue("model_f_edge", 32'(bus.f_edge_o), 32'(m_fe));
        compareValue("model_err", 32'(bus.err_o), 32'(m_err));
    end

    // Drives a request immediately; it is sampled by the next rising edge,
    // after which the inputs are scrambled to prove they were registered.
    task automatic startNow(input vec_t v);
        bus.f1_i        = v.f1;
        bus.f2_i        = v.f2;
        bus.L1_i        = v.l1;
        bus.L2_i        = v.l2;
        bus.threshold_i = v.th;
        bus.start_i     = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i     = 1'b0;
        bus.f1_i        = 16'($urandom);
        bus.f2_i        = 16'($urandom);
        bus.L1_i        = 18'($urandom);
        bus.L2_i        = 18'($urandom);
        bus.threshold_i = 18'($urandom);
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        startNow(v);
    endtask

    // Called just after the accepting edge; waits (bounded) for valid_o.
    task automatic checkOutput(input vec_t v);
        int edges = 0;
        while (bus.valid_o !== 1'b1 && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        compareValue({v.name, "_latency"}, 32'(edges), 32'(LAT));
        compareValue({v.name, "_f_edge"}, 32'(bus.f_edge_o), 32'(v.fe));
        compareValue({v.name, "_err"}, 32'(bus.err_o), 32'(v.err));
    endtask

    vec_t vecs[9];
    int   extra;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vecs[0] = '{"midpoint",   16'h0010, 16'h0011, 18'h3D800, 18'h3EC00, TH_M30_DB, 24'h001080, 1'b0};
        vecs[1] = '{"truncation", 16'h0100, 16'h0104, 18'h3DC00, 18'h3E500, TH_M30_DB, 24'h0102A8, 1'b0};
        vecs[2] = '{"th_eq_l1",   16'h0010, 16'h0011, 18'h3D800, 18'h3EC00, 18'h3D800, 24'h001000, 1'b0};
        vecs[3] = '{"th_eq_l2",   16'h0010, 16'h0011, 18'h3D800, 18'h3EC00, 18'h3EC00, 24'h001100, 1'b0};
        // -24 dB still lies inside the -40..-20 bracket: q = floor(16*256/20) = 0xCC.
        vecs[4] = '{"th_m24db",   16'h0010, 16'h0011, 18'h3D800, 18'h3EC00, 18'h3E800, 24'h0010CC, 1'b0};
        vecs[5] = '{"clamp_high", 16'h0010, 16'h0011, 18'h3D800, 18'h3EC00, 18'h3F000, 24'h001100, 1'b0};
        vecs[6] = '{"below_l1",   16'h0010, 16'h0011, 18'h3D800, 18'h3EC00, 18'h3D000, 24'h001000, 1'b0};
        vecs[7] = '{"falling",    16'h0030, 16'h0032, 18'h3EC00, 18'h3D800, TH_M30_DB, 24'h003100, 1'b0};
        vecs[8] = '{"degenerate", 16'h0020, 16'h0022, 18'h3E200, 18'h3E200, 18'h3E200, 24'h002000, 1'b1};

        bus.start_i     = 1'b0;
        bus.f1_i        = '0;
        bus.f2_i        = '0;
        bus.L1_i        = '0;
        bus.L2_i        = '0;
        bus.threshold_i = '0;
        rst_n           = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        compareValue("reset_f_edge", 32'(bus.f_edge_o), 32'h0);
        compareValue("reset_valid", 32'(bus.valid_o), 32'h0);
        compareValue("reset_busy", 32'(bus.busy_o), 32'h0);
        compareValue("reset_err", 32'(bus.err_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] directed vectors");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i]);
        end

        $display("[TB] back-to-back requests 12 cycles apart");
        applyStimulus(vecs[0]);
        checkOutput(vecs[0]);
        startNow(vecs[1]);
        checkOutput(vecs[1]);

        $display("[TB] starts while busy and in DONE are ignored");
        applyStimulus(vecs[0]);
        repeat (3) @(posedge clk);
        #1;
        bus.f1_i        = vecs[8].f1;
        bus.f2_i        = vecs[8].f2;
        bus.L1_i        = vecs[8].l1;
        bus.L2_i        = vecs[8].l2;
        bus.threshold_i = vecs[8].th;
        bus.start_i     = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        bus.start_i = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        compareValue("ignore_valid", 32'(bus.valid_o), 32'h1);
        compareValue("ignore_f_edge", 32'(bus.f_edge_o), 32'h001080);
        compareValue("ignore_err", 32'(bus.err_o), 32'h0);
        extra = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.valid_o === 1'b1) extra++;
        end
        compareValue("ignore_extra_valid", 32'(extra), 32'h0);
        compareValue("ignore_busy_after", 32'(bus.busy_o), 32'h0);

        $display("[TB] reset during DIV");
        applyStimulus(vecs[1]);
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        compareValue("abort_f_edge", 32'(bus.f_edge_o), 32'h0);
        compareValue("abort_valid", 32'(bus.valid_o), 32'h0);
        compareValue("abort_busy", 32'(bus.busy_o), 32'h0);
        compareValue("abort_err", 32'(bus.err_o), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (bus.valid_o === 1'b1) extra++;
        end
        compareValue("abort_no_valid", 32'(extra), 32'h0);
        applyStimulus(vecs[1]);
        checkOutput(vecs[1]);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
